// File: rtl/inst_encoder.sv
// RV32I instruction encoder: range-checks an immediate, scatters it into the
// format's bit positions and queues {word, address} pairs in a small FIFO.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [15:0] word_cnt
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_R = 3'd5
    } fmt_e;

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]  next_addr_q, next_addr_d;
    logic         err_q, err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;
    logic [15:0]  word_cnt_q, word_cnt_d;
    logic [31:0]  inst_mem [DEPTH];
    logic [31:0]  addr_mem [DEPTH];

    logic signed [31:0] imm_s;
    logic [31:0]  enc_word;
    logic         legal, empty, full, accept, push, reject, pop;

    assign imm_s = $signed(imm);

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        enc_word = '0;
        legal    = 1'b0;
        case (fmt_e'(fmt))
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                legal    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                legal    = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal    = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
            end
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
                legal    = 1'b1;
            end
            default: begin
                enc_word = '0;
                legal    = 1'b0;
            end
        endcase
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign reject    = accept && !legal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        next_addr_d = next_addr_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;
        if (push) begin
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            next_addr_d = next_addr_q + 32'd4;
            word_cnt_d  = word_cnt_q + 16'd1;
        end
        if (reject) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            next_addr_q <= BASE_ADDR;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            next_addr_q <= next_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag masks stale entries from the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q[AW-1:0]] <= enc_word;
            addr_mem[wr_ptr_q[AW-1:0]] <= next_addr_q;
        end
    end

    assign out_inst = empty ? 32'd0 : inst_mem[rd_ptr_q[AW-1:0]];
    assign out_addr = empty ? 32'd0 : addr_mem[rd_ptr_q[AW-1:0]];
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a queue-based reference model checked
// every cycle, plus hand-computed words and addresses from directed bundles.
module tb_inst_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst, out_addr;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] word_cnt;

    inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .err(err), .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    ent_t        mq[$];
    ent_t        log_q[$];
    logic [31:0] m_addr = BASE;
    logic        m_err = 1'b0;
    int          m_errcnt = 0;
    int          m_wcnt = 0;

    function automatic bit model_legal(input logic [2:0] f, input logic [31:0] im);
        longint v;
        v = longint'($signed(im));
        case (f)
            3'd0, 3'd1: return (v >= -2048) && (v <= 2047);
            3'd2:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            3'd3:       return (im % 4096) == 0;
            3'd4:       return (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            3'd5:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] bits_of(input logic [31:0] x, input int hi, input int lo);
        return (x >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] model_enc(input logic [2:0] f, input logic [6:0] op,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [4:0] d, input logic [4:0] s1,
                                              input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'(op);
        case (f)
            3'd0: w |= (bits_of(im, 11, 0) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
            3'd1: w |= (bits_of(im, 11, 5) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                     | (32'(f3) << 12) | (bits_of(im, 4, 0) << 7);
            3'd2: w |= (bits_of(im, 12, 12) << 31) | (bits_of(im, 10, 5) << 25) | (32'(s2) << 20)
                     | (32'(s1) << 15) | (32'(f3) << 12) | (bits_of(im, 4, 1) << 8)
                     | (bits_of(im, 11, 11) << 7);
            3'd3: w |= (im & 32'hFFFF_F000) | (32'(d) << 7);
            3'd4: w |= (bits_of(im, 20, 20) << 31) | (bits_of(im, 10, 1) << 21)
                     | (bits_of(im, 11, 11) << 20) | (bits_of(im, 19, 12) << 12) | (32'(d) << 7);
            default: w |= (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                        | (32'(f3) << 12) | (32'(d) << 7);
        endcase
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_addr   = BASE;
            m_err    = 1'b0;
            m_errcnt = 0;
            m_wcnt   = 0;
        end else begin
            bit   acc, pop;
            ent_t e;
            acc = in_valid && (mq.size() < DEPTH);
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (model_legal(fmt, imm)) begin
                    e.inst = model_enc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
                    e.addr = m_addr;
                    mq.push_back(e);
                    m_addr = m_addr + 32'd4;
                    m_wcnt = (m_wcnt + 1) % 65536;
                end else begin
                    m_err = 1'b1;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            bit          ev;
            logic [31:0] ei, ea;
            ev = mq.size() > 0;
            ei = ev ? mq[0].inst : 32'd0;
            ea = ev ? mq[0].addr : 32'd0;
            check("out_valid", 32'(out_valid), 32'(ev));
            check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            check("out_inst", out_inst, ei);
            check("out_addr", out_addr, ea);
            check("err", 32'(err), 32'(m_err));
            check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
            check("word_cnt", 32'(word_cnt), 32'(m_wcnt));
            if (out_valid && out_ready) begin
                ent_t e;
                e.inst = out_inst;
                e.addr = out_addr;
                log_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Leaves in_valid high; caller follows with another send or idle without an edge in between.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        bit acc, done;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: bundle fmt %0d not accepted within 50 cycles", f);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: FIFO not empty after 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] im;
    } bvec_t;

    logic [31:0] exp_inst [7];
    logic [31:0] exp_addr [7];
    bvec_t       bt [13];
    int          base_n;

    initial begin
        exp_inst[0] = 32'h00A00083; exp_inst[1] = 32'h00100523; exp_inst[2] = 32'h00208863;
        exp_inst[3] = 32'h1869F0B7; exp_inst[4] = 32'h008000EF; exp_inst[5] = 32'h403100B3;
        exp_inst[6] = 32'hFFF00093;
        for (int i = 0; i < 7; i++) exp_addr[i] = BASE + 32'(4 * i);

        bt[0]  = '{3'd0, -32'sd2048};   bt[1]  = '{3'd0, 32'sd2047};
        bt[2]  = '{3'd0, -32'sd2049};   bt[3]  = '{3'd1, 32'sd2048};
        bt[4]  = '{3'd2, 32'sd4094};    bt[5]  = '{3'd2, -32'sd4096};
        bt[6]  = '{3'd2, 32'sd4096};    bt[7]  = '{3'd4, 32'sd1048574};
        bt[8]  = '{3'd4, -32'sd1048576}; bt[9] = '{3'd4, 32'sd1048576};
        bt[10] = '{3'd4, 32'sd7};       bt[11] = '{3'd3, 32'hFFFF_F000};
        bt[12] = '{3'd7, 32'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_inst", out_inst, 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Model pins against hand-computed words
        check("model_I", model_enc(3'd0, 7'h03, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd10), 32'h00A00083);
        check("model_B", model_enc(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16), 32'h00208863);

        // Back-to-back legal bundles
        out_ready = 1'b1;
        send(3'd0, 7'h03, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd10);
        send(3'd1, 7'h23, 3'd0, 7'd0,  5'd0, 5'd0, 5'd1, 32'd10);
        send(3'd2, 7'h63, 3'd0, 7'd0,  5'd0, 5'd1, 5'd2, 32'd16);
        send(3'd3, 7'h37, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'h1869F000);
        send(3'd4, 7'h6F, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'd8);
        send(3'd5, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF);
        send(3'd0, 7'h13, 3'd0, 7'd0,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        idle();
        drain();
        check("log_size_7", 32'(log_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < log_q.size(); i++) begin
            check($sformatf("word%0d_inst", i), log_q[i].inst, exp_inst[i]);
            check($sformatf("word%0d_addr", i), log_q[i].addr, exp_addr[i]);
        end

        // Rejects
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        send(3'd2, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        send(3'd3, 7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1000_0001);
        send(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rej_err", 32'(err), 32'd1);
        check("rej_err_cnt", 32'(err_cnt), 32'd4);
        check("rej_word_cnt", 32'(word_cnt), 32'd7);
        check("rej_no_output", 32'(log_q.size()), 32'd7);

        // Backpressure: two fill the FIFO, third waits
        base_n = log_q.size();
        out_ready = 1'b0;
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd1);
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd2);
        fork
            send(3'd0, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", 32'(in_ready), 32'd0);
                    check("bp_head_stable", out_inst, 32'h00100193);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle();
        drain();
        check("bp_count", 32'(log_q.size() - base_n), 32'd3);
        for (int i = 0; i < 3 && base_n + i < log_q.size(); i++) begin
            check($sformatf("bp%0d_inst", i), log_q[base_n + i].inst, 32'h00000193 | (32'(i + 1) << 20));
            check($sformatf("bp%0d_addr", i), log_q[base_n + i].addr, 32'h1C + 32'(4 * i));
        end

        // Immediate boundaries
        for (int i = 0; i < 13; i++)
            send(bt[i].f, 7'h13, 3'd1, 7'd0, 5'd4, 5'd5, 5'd6, bt[i].im);
        idle();
        drain();
        check("bnd_err_cnt", 32'(err_cnt), 32'd10);

        // Simultaneous push and pop at occupancy 1
        base_n = log_q.size();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++)
            send(3'd0, 7'h13, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'(i));
        idle();
        drain();
        check("pp_count", 32'(log_q.size() - base_n), 32'd11);
        for (int i = 1; i < 11 && base_n + i < log_q.size(); i++)
            check("pp_addr_step", log_q[base_n + i].addr, log_q[base_n + i - 1].addr + 32'd4);

        // Reset mid-stream with two words buffered
        out_ready = 1'b0;
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd100);
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd101);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_inst", out_inst, 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_n = log_q.size();
        out_ready = 1'b1;
        send(3'd0, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd5);
        idle();
        drain();
        check("post_rst_count", 32'(log_q.size() - base_n), 32'd1);
        if (log_q.size() > base_n) begin
            check("post_rst_addr", log_q[base_n].addr, BASE);
            check("post_rst_inst", log_q[base_n].inst, 32'h00500113);
        end
        check("post_rst_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential RV32I instruction encoder: the inverse of the immediate generator. It accepts instruction fields (format, opcode, funct3/funct7, register indices, signed immediate), range-checks the immediate and scatters it into the correct bit positions. It emits 32-bit instruction words with sequential word addresses through a small output FIFO. It sits in the program-loader path that fills instruction memory for the single-cycle core and its benches.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address assigned to the first emitted word.
- `DEPTH`, default 2: output FIFO entries. Must be a power of two, at least 2.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder can accept a bundle.
- `fmt` input 3: format select. 0=I, 1=S, 2=B, 3=U, 4=J, 5=R; 6 and 7 are illegal.
- `opcode` input 7: opcode field, copied to bits [6:0].
- `funct3` input 3: copied to [14:12] for I/S/B/R; ignored for U/J.
- `funct7` input 7: copied to [31:25] for R only.
- `rd`, `rs1`, `rs2` input 5 each: register indices, placed per format; unused ones are ignored.
- `imm` input 32: immediate, two's complement.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts head.
- `out_inst` output 32: encoded instruction at head.
- `out_addr` output 32: byte address of head word.
- `err` output 1: sticky, set on any rejected bundle.
- `err_cnt` output 8: count of rejected bundles, saturating at 255.
- `word_cnt` output 16: count of words pushed into the FIFO, wraps.

## Operation
- An input is accepted when `in_valid && in_ready`.
- `in_ready` = FIFO occupancy < `DEPTH`. It does not depend on `out_ready` in the same cycle.
- Encoding on accept:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}; `imm` ignored.
- Legality checks (bundle rejected if any check fails):
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - fmt 6 or 7: illegal.
- Rejected bundle: it is still consumed (handshake completes). Nothing is pushed, `err` is set, `err_cnt` increments (saturating), and `word_cnt` and the address counter are unchanged.
- Legal bundle: {encoded word, next_addr} is pushed. `next_addr` then advances by 4 and wraps modulo 2^32. `word_cnt` increments.
- Pop occurs when `out_valid && out_ready`. `out_inst`/`out_addr` always show the head entry; both read 0 when the FIFO is empty.
- Push and pop in the same cycle: occupancy is unchanged. This is allowed when full, but `in_ready` was already low, so in practice it occurs only below full.
- The FIFO is circular, with read/write pointers of width log2(`DEPTH`)+1. Full = MSBs differ and the low bits are equal.

## Timing
- Reset (asserted asynchronously, released synchronously to `clk`): FIFO empty, `out_valid`=0, `out_inst`=0, `out_addr`=0, `in_ready`=1, `next_addr`=`BASE_ADDR`, `err`=0, `err_cnt`=0, `word_cnt`=0.
- Latency: a bundle accepted at edge N into an empty FIFO gives `out_valid`=1 with its word after edge N.
- Throughput: one word per cycle when `out_ready` is held high.
- Stalls: with `out_ready`=0, at most `DEPTH` words buffer; `in_ready` drops the cycle after the FIFO becomes full.
- `out_valid` and head data remain stable while `out_ready`=0.
- Reset mid-stream: buffered words are discarded, and addresses restart at `BASE_ADDR`. No output toggles spuriously after release.
- `err` clears only on reset.

## Test plan
- I/S/B/U/J bundles back-to-back with `out_ready`=1. Expected words, at addresses 0x0, 0x4, 0x8, 0xC, 0x10:
  - I: opcode 0x03, rd 1, rs1 0, imm 10 → 0x00A00083.
  - S: opcode 0x23, rs2 1, rs1 0, imm 10 → 0x00100523.
  - B: opcode 0x63, rs1 1, rs2 2, imm 16 → 0x00208863.
  - U: opcode 0x37, rd 1, imm 0x1869F000 → 0x1869F0B7.
  - J: opcode 0x6F, rd 1, imm 8 → 0x008000EF.
- R bundle: opcode 0x33, funct7 0x20, rs2 3, rs1 2, rd 1, funct3 0 → 0x403100B3. Negative I bundle: imm -1, rs1 0, rd 1, opcode 0x13 → 0xFFF00093.
- Reject cases, each consumed with no word emitted:
  - I imm 2048.
  - B imm 3.
  - U imm 0x1000_0001.
  - fmt 6.
  - After all four: `err`=1, `err_cnt`=4, `word_cnt` and `next_addr` unchanged.
- Backpressure: hold `out_ready`=0 and offer 3 legal bundles. `in_ready` falls after 2 accepts and the 3rd waits. Release `out_ready`: all 3 words emerge in order, with no loss or duplication.
- Simultaneous push and pop at occupancy 1 for 10 cycles: occupancy stays 1 and addresses increment by 4 per word.
- Assert `rst_n` low with 2 words buffered: `out_valid`=0 immediately. After release, the next word carries address `BASE_ADDR`, and `err_cnt`=0.
